// File: rtl/sysbus_pkg.sv
// System-bus constants and writeback state encoding.
// Shared by the line writeback and line-fill engines.
package sysbus_pkg;
   localparam logic       SYSBUS_READ        = 1'b1;
   localparam logic       SYSBUS_WRITE       = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY      = 4'b0001;
   localparam int         SYSBUS_RW_SHIFT    = 12;
   localparam int         SYSBUS_SPACE_SHIFT = 8;
   localparam int         LINE_WORDS         = 8;

   typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, DONE} wb_state_t;
endpackage

// File: rtl/line_writeback.sv
// Writes one 64-byte victim line to memory: arbitrate, address beat, 8 data beats.
// Optional LINE_WB_TIMEOUT_EN: re-arbitrate and pulse error when the address beat is not acked.
module line_writeback
   import sysbus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [BUS_DATA_WIDTH-1:0]            addr,
   input  logic [BUS_DATA_WIDTH*LINE_WORDS-1:0] data,
   output logic                                 abtr_reqcyc,
   input  logic                                 abtr_grant,
   output logic                                 bus_busy,
   output logic                                 main_bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0]            main_bus_req,
   output logic [BUS_TAG_WIDTH-1:0]             main_bus_reqtag,
   input  logic                                 main_bus_reqack,
   output logic                                 ready,
   output logic                                 error
);

   localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG =
      (BUS_TAG_WIDTH'(SYSBUS_WRITE) << SYSBUS_RW_SHIFT) |
      (BUS_TAG_WIDTH'(SYSBUS_MEMORY) << SYSBUS_SPACE_SHIFT);
   localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

   wb_state_t                                 state, state_n;
   logic [2:0]                                cnt, cnt_n;
   logic [BUS_DATA_WIDTH-1:0]                 addr_q, addr_n;
   logic [LINE_WORDS-1:0][BUS_DATA_WIDTH-1:0] line_q, line_n;
   logic                                      err_n;
   logic                                      on_bus_n;

`ifdef LINE_WB_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_q, wait_n;
`endif

   // Low address bits are dropped by alignment; the timeout length only matters with the feature.
   logic unused_cfg;
   assign unused_cfg = ^{addr[5:0], TIMEOUT_CYCLES[0]};

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = addr_q;
      line_n  = line_q;
      err_n   = 1'b0;
`ifdef LINE_WB_TIMEOUT_EN
      wait_n  = wait_q;
`endif
      unique case (state)
         IDLE, DONE: if (enable) begin
            addr_n  = {addr[BUS_DATA_WIDTH-1:6], 6'b0};
            line_n  = data;
            state_n = ARB;
         end
         ARB: if (abtr_grant) begin
            state_n = ADDR;
`ifdef LINE_WB_TIMEOUT_EN
            wait_n  = '0;
`endif
         end
         ADDR: if (main_bus_reqack) begin
            state_n = DATA;
            cnt_n   = '0;
         end
`ifdef LINE_WB_TIMEOUT_EN
         else if (wait_q == WAIT_LAST) begin
            // Give the bus back and retry arbitration; the latched line is kept.
            state_n = ARB;
            err_n   = 1'b1;
         end else begin
            wait_n  = wait_q + 8'd1;
         end
`endif
         DATA: begin
            cnt_n = cnt + 3'd1;
            if (cnt == LAST_BEAT) state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign on_bus_n = (state_n == ADDR) || (state_n == DATA);

   // Outputs are computed from the next state so they change on the entering edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         addr_q          <= '0;
         line_q          <= '0;
         abtr_reqcyc     <= 1'b0;
         bus_busy        <= 1'b0;
         main_bus_reqcyc <= 1'b0;
         main_bus_req    <= '0;
         main_bus_reqtag <= '0;
         ready           <= 1'b0;
         error           <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         addr_q          <= addr_n;
         line_q          <= line_n;
         abtr_reqcyc     <= (state_n == ARB) || on_bus_n;
         bus_busy        <= on_bus_n;
         main_bus_reqcyc <= on_bus_n;
         main_bus_req    <= (state_n == ADDR) ? addr_n :
                            (state_n == DATA) ? line_n[cnt_n] : '0;
         main_bus_reqtag <= on_bus_n ? WR_TAG : '0;
         ready           <= (state_n == DONE);
         error           <= err_n;
      end
   end

`ifdef LINE_WB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wait_q <= '0;
      else       wait_q <= wait_n;
   end
`endif

endmodule

// File: doc/line_writeback.md
Name: line_writeback

Overview:
- Write-side partner of the cache-line fill engine. Takes one 64-byte line plus its address from the D-cache eviction path and writes it to main memory over the system bus.
- Sequence: arbiter request → one address beat with write/memory tag → eight 64-bit data beats, lowest word first.
- Sits between the cache victim buffer and the bus arbiter, beside the line-fill engine.

Parameters:
- BUS_DATA_WIDTH, 64, width of one bus beat; line is 8 beats.
- BUS_TAG_WIDTH, 13, width of main_bus_reqtag.
- TIMEOUT_CYCLES, 255, max cycles to wait for main_bus_reqack (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  start request; sampled only in IDLE or DONE.
- addr  in  BUS_DATA_WIDTH  line address; bits [5:0] ignored.
- data  in  BUS_DATA_WIDTH*8  line data; word k = data[64k+63:64k].
- abtr_reqcyc  out  1  arbiter request.
- abtr_grant  in  1  arbiter grant.
- bus_busy  out  1  bus held by this block.
- main_bus_reqcyc  out  1  request beat valid.
- main_bus_req  out  BUS_DATA_WIDTH  address or data beat.
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- main_bus_reqack  in  1  memory accepted address beat.
- ready  out  1  line written; held until next accepted enable.
- error  out  1  one-cycle pulse on ack timeout (constant 0 without the optional feature).

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; beat counter 0; internal address/data latches 0.
- IDLE: if enable=1, latch {addr[63:6],6'b0} and data, then go to ARB.
- ARB: abtr_reqcyc=1. If abtr_grant=1, go to ADDR on the next edge. bus_busy rises with ADDR entry.
- ADDR: drive the address beat.
  - main_bus_reqcyc=1, main_bus_req=latched aligned address.
  - main_bus_reqtag = SYSBUS_WRITE<<12 | SYSBUS_MEMORY<<8 = 13'h0100.
  - Hold the beat until main_bus_reqack=1, then go to DATA with counter=0.
- DATA: main_bus_reqcyc=1, main_bus_req=word[counter], tag unchanged. Counter increments every cycle, with no stall. When counter=7, go to DONE.
  - Exactly 8 data beats, on consecutive cycles, words 0..7.
- DONE: release the bus.
  - ready=1; abtr_reqcyc, bus_busy and main_bus_reqcyc are 0.
  - enable=1 re-latches addr/data, clears ready and goes to ARB on the same edge.
- Outputs are registered: each output changes on the clock edge that enters the state. main_bus_req is 0 outside ADDR/DATA.
- Latency, no stalls: grant→first addr beat 1 cycle; ack→word0 1 cycle; word7→ready 1 cycle.
- Signals held constant during ARB/ADDR/DATA:
  - abtr_reqcyc stays 1 until DONE.
  - Changes on enable, addr and data are ignored.
- Grant dropped mid-transfer: ignored; the line always completes once ADDR is entered.
- Counter is 3 bits. No wrap-around beyond 7 is reachable.

Optional Feature:
- Macro: LINE_WB_TIMEOUT_EN.
- With the macro:
  - An 8-bit wait counter runs in ADDR.
  - If TIMEOUT_CYCLES cycles pass without main_bus_reqack, drop main_bus_reqcyc and bus_busy and return to ARB (re-arbitrate).
  - Pulse error for 1 cycle.
  - Latched line is kept; retries are unlimited.
- Without the macro: ADDR waits indefinitely, error is tied 0, no wait counter exists.

Decomposition:
- Shared package sysbus_pkg holds:
  - SYSBUS_READ=1'b1, SYSBUS_WRITE=1'b0, SYSBUS_MEMORY=4'b0001, tag shift constants (12, 8).
  - LINE_WORDS=8.
  - State enum wb_state_t {IDLE, ARB, ADDR, DATA, DONE}.
  - The line-fill engine is to import the same package.
- No sub-module: one always_ff (async reset) and one always_comb next-state block. The 512-bit latch-and-mux stays inline.

Test Plan:
- Reset during DATA at counter=4 → all outputs 0 immediately (asynchronous); a later enable restarts from word0 with the newly latched line.
- Basic line: enable with addr=64'h1234_567F, data word k=64'hA0+k; grant after 2 cycles; reqack on first ADDR cycle:
  - Address beat main_bus_req=64'h1234_5640, tag=13'h0100.
  - Then 8 consecutive beats 64'hA0..64'hA7.
  - ready=1 the next cycle.
- Ack stall: hold reqack=0 for 5 cycles → address beat is repeated for 6 cycles; word0 appears the cycle after reqack.
- Back-to-back: assert enable in the first DONE cycle with a new addr=64'h8000 → ready falls and abtr_reqcyc rises on the same edge; second address beat =64'h8000.
- Input churn: change addr/data during DATA → the beats still carry the originally latched values.
- LINE_WB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and reqack held 0:
  - After 4 ADDR cycles: error pulses once, main_bus_reqcyc=0, state returns to ARB.
  - Second attempt with ack completes with the original data.
